// File: rtl/trojan_response_checker_if.sv
// trojan_response_checker_if: valid/ready stream carrying (pattern, response) samples
interface trojan_response_checker_if #(parameter int N_IN = 5);
  logic s_valid;
  logic s_ready;
  logic [N_IN-1:0] s_pattern;
  logic s_response;
  modport master(output s_valid, s_pattern, s_response, input s_ready);
  modport slave(input s_valid, s_pattern, s_response, output s_ready);
endinterface

// File: rtl/trojan_response_checker.sv
// trojan_response_checker: compares streamed responses against a golden table, tracks coverage and mismatches.
// Optional idle-stream watchdog enabled by defining CHECKER_TIMEOUT_EN.
module trojan_response_checker #(
  parameter int N_IN = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CK,
  input  logic reset,
  input  logic load_en,
  input  logic [N_IN-1:0] load_addr,
  input  logic load_data,
  input  logic start,
  trojan_response_checker_if.slave s,
  output logic busy,
  output logic mismatch,
  output logic [N_IN-1:0] first_bad,
  output logic [N_IN:0] mismatch_count,
  output logic done,
  output logic pass,
  output logic timeout
);
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  localparam logic [N_IN:0] CNT_MAX = '1;
  state_t state;
  logic [2**N_IN-1:0] cov;
  logic golden [2**N_IN];
  logic v1, bad1, hs, expired;
  logic [N_IN-1:0] pat1;
  assign s.s_ready = state == CHECK;
  assign busy = state == CHECK;
  assign hs = s.s_valid && s.s_ready;
  always_ff @(posedge CK)
    if (state == IDLE && load_en && !start) golden[load_addr] <= load_data;
`ifdef CHECKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
  always_ff @(posedge CK or posedge reset)
    if (reset) idle_cnt <= '0;
    else idle_cnt <= (state != CHECK || hs || start) ? '0 : idle_cnt + 1'b1;
  assign expired = idle_cnt == IW'(TIMEOUT_CYCLES);
`else
  assign expired = TIMEOUT_CYCLES < 0;
`endif
  // Samples are staged one cycle so the compare result lands at the edge after the handshake.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cov <= '0;
      v1 <= 1'b0;
      bad1 <= 1'b0;
      pat1 <= '0;
      mismatch <= 1'b0;
      first_bad <= '0;
      mismatch_count <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
    end else if (start) begin
      state <= CHECK;
      cov <= '0;
      v1 <= 1'b0;
      mismatch <= 1'b0;
      first_bad <= '0;
      mismatch_count <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
    end else begin
      v1 <= hs;
      pat1 <= s.s_pattern;
      bad1 <= s.s_response != golden[s.s_pattern];
      mismatch <= v1 && bad1;
      if (v1 && bad1) begin
        if (mismatch_count == '0) first_bad <= pat1;
        if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + 1'b1;
      end
      if (hs) cov[s.s_pattern] <= 1'b1;
      if (state == CHECK && (&cov || expired)) begin
        state <= DONE;
        timeout <= !(&cov);
      end
      // pass is latched once, so a straggler accepted after coverage cannot change it
      if (state == DONE && !done) begin
        done <= 1'b1;
        pass <= mismatch_count == '0 && !timeout;
      end
    end
  end
endmodule

// File: tb/tb_trojan_response_checker.sv
// tb_trojan_response_checker: directed table-driven checks of the response checker (default build).
module tb_trojan_response_checker;
  logic CK = 1'b0;
  logic reset = 1'b1;
  logic load_en = 1'b0;
  logic [4:0] load_addr = '0;
  logic load_data = 1'b0;
  logic start = 1'b0;
  logic busy, mismatch, done, pass, timeout;
  logic [4:0] first_bad;
  logic [5:0] mismatch_count;
  int total = 0;
  int bad = 0;
  trojan_response_checker_if #(.N_IN(5)) s_if();
  trojan_response_checker #(.N_IN(5), .TIMEOUT_CYCLES(64)) dut (
    .CK(CK), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .s(s_if), .busy(busy), .mismatch(mismatch), .first_bad(first_bad),
    .mismatch_count(mismatch_count), .done(done), .pass(pass), .timeout(timeout)
  );
  always #5 CK = ~CK;
  typedef struct {
    logic [31:0] mask;
    int cnt;
    int fb;
    bit ok;
  } rec_t;
  rec_t tbl[6];
  task automatic tick();
    @(posedge CK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit par(input int p);
    return ^p[4:0];
  endfunction
  task automatic send(input int p, input bit r);
    s_if.s_valid = 1'b1;
    s_if.s_pattern = p[4:0];
    s_if.s_response = r;
    tick();
    s_if.s_valid = 1'b0;
  endtask
  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(i, par(i));
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{32'h0000_0000, 0, 0, 1'b1};
    tbl[1] = '{32'h0040_0000, 1, 22, 1'b0};
    tbl[2] = '{32'h0000_0001, 1, 0, 1'b0};
    tbl[3] = '{32'h8000_0000, 1, 31, 1'b0};
    tbl[4] = '{32'h0000_0300, 2, 8, 1'b0};
    tbl[5] = '{32'hffff_ffff, 32, 0, 1'b0};
    s_if.s_valid = 1'b0;
    s_if.s_pattern = '0;
    s_if.s_response = 1'b0;
    repeat (2) tick();
    chk("rst_ready", s_if.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_first_bad", first_bad, 0);
    chk("rst_count", mismatch_count, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) begin
      load_en = 1'b1;
      load_addr = a[4:0];
      load_data = par(a);
      tick();
    end
    load_en = 1'b0;
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      chk("start_busy", busy, 1);
      chk("start_ready", s_if.s_ready, 1);
      chk("start_done", done, 0);
      chk("start_count", mismatch_count, 0);
      for (int i = 0; i < 32; i++) begin
        s_if.s_valid = 1'b1;
        s_if.s_pattern = i[4:0];
        s_if.s_response = par(i) ^ tbl[r].mask[i];
        tick();
        if (i > 0) chk("pulse", mismatch, tbl[r].mask[i-1]);
      end
      s_if.s_valid = 1'b0;
      tick();
      chk("pulse_last", mismatch, tbl[r].mask[31]);
      chk("t1_done", done, 0);
      chk("t1_ready", s_if.s_ready, 0);
      tick();
      chk("done", done, 1);
      chk("pass", pass, tbl[r].ok);
      chk("count", mismatch_count, tbl[r].cnt);
      chk("first_bad", first_bad, tbl[r].fb);
      chk("done_busy", busy, 0);
      chk("done_timeout", timeout, 0);
    end
    pulse_start();
    send_range(0, 31);
    send(5, ~par(5));
    tick();
    chk("extra_done", done, 1);
    chk("extra_pass", pass, 1);
    chk("extra_count", mismatch_count, 1);
    chk("extra_mismatch", mismatch, 1);
    pulse_start();
    repeat (3) send(3, ~par(3));
    send_range(0, 30);
    repeat (3) tick();
    chk("dup_count", mismatch_count, 3);
    chk("dup_first_bad", first_bad, 3);
    chk("gap_done", done, 0);
    chk("gap_busy", busy, 1);
    send(31, par(31));
    tick();
    tick();
    chk("gap_fill_done", done, 1);
    chk("gap_fill_pass", pass, 0);
    chk("gap_fill_count", mismatch_count, 3);
    pulse_start();
    for (int i = 0; i < 10; i++) send(i, par(i) ^ (i == 4));
    tick();
    chk("pre_restart_count", mismatch_count, 1);
    s_if.s_valid = 1'b1;
    s_if.s_pattern = 5'd0;
    s_if.s_response = ~par(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    s_if.s_valid = 1'b0;
    chk("restart_count", mismatch_count, 0);
    chk("restart_first_bad", first_bad, 0);
    tick();
    chk("restart_discard", mismatch, 0);
    send_range(10, 31);
    repeat (3) tick();
    chk("restart_partial_done", done, 0);
    chk("restart_partial_busy", busy, 1);
    send_range(0, 9);
    tick();
    tick();
    chk("restart_done", done, 1);
    chk("restart_pass", pass, 1);
    chk("restart_final_count", mismatch_count, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) send(i, par(i) ^ (i == 2));
    repeat (70) tick();
    chk("idle_busy", busy, 1);
    chk("idle_timeout", timeout, 0);
    chk("idle_done", done, 0);
    chk("idle_count", mismatch_count, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_if.s_ready, 0);
    chk("mid_rst_count", mismatch_count, 0);
    chk("mid_rst_first_bad", first_bad, 0);
    chk("mid_rst_outs", {mismatch, done, pass, timeout}, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_after_rst", busy, 0);
    load_en = 1'b1;
    load_addr = 5'd7;
    load_data = ~par(7);
    pulse_start();
    load_en = 1'b0;
    send_range(0, 31);
    tick();
    tick();
    chk("collide_done", done, 1);
    chk("collide_pass", pass, 1);
    chk("collide_count", mismatch_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
